// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_ctrl (with helper uart_mmio_fifo)
//  Purpose  : Bus-mapped UART controller: TX/RX byte FIFOs sequencing one
//             async transmitter/receiver pair; 16550-style DATA and LSR.
//  Revision : 1.0  initial release
// ============================================================================

module uart_mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_en,
    input  logic       bus_we,
    input  logic [2:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       rx_clear
);
    localparam logic [2:0] c_ADDR_DATA    = 3'd0;
    localparam logic [2:0] c_ADDR_LSR     = 3'd5;

    localparam logic [1:0] c_TX_IDLE      = 2'd0;
    localparam logic [1:0] c_TX_WAIT_BUSY = 2'd1;
    localparam logic [1:0] c_TX_WAIT_DONE = 2'd2;

    localparam logic [1:0] c_RX_IDLE      = 2'd0;
    localparam logic [1:0] c_RX_CLEAR     = 2'd1;
    localparam logic [1:0] c_RX_WAIT      = 2'd2;

    localparam logic [1:0] c_BUSY_TIMEOUT = 2'd3;

    logic [1:0] r_tx_state;
    logic [1:0] r_rx_state;
    logic [1:0] r_tx_wait_cnt;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_ack;
    logic [7:0] r_rdata;
    logic       r_overrun;

    logic       w_wr_data;
    logic       w_rd_data;
    logic       w_rd_lsr;
    logic       w_tx_pop;
    logic       w_rx_pop;
    logic       w_rx_capture;
    logic       w_rx_drop;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic [7:0] w_tx_head;
    logic [7:0] w_rx_head;
    logic [7:0] w_lsr;
    logic [7:0] w_rdata_next;

    assign w_wr_data    = bus_en &&  bus_we && (bus_addr == c_ADDR_DATA);
    assign w_rd_data    = bus_en && !bus_we && (bus_addr == c_ADDR_DATA);
    assign w_rd_lsr     = bus_en && !bus_we && (bus_addr == c_ADDR_LSR);

    assign w_tx_pop     = (r_tx_state == c_TX_IDLE) && !w_tx_empty && !tx_busy;
    assign w_rx_pop     = w_rd_data && !w_rx_empty;
    assign w_rx_capture = (r_rx_state == c_RX_IDLE) && rx_ready;
    assign w_rx_drop    = w_rx_capture && w_rx_full && !w_rx_pop;

    assign w_lsr = {1'b0, w_tx_empty && (r_tx_state == c_TX_IDLE), !w_tx_full,
                    3'b000, r_overrun, !w_rx_empty};

    uart_mmio_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_data),
        .i_pop   (w_tx_pop),
        .i_wdata (bus_wdata),
        .o_head  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    uart_mmio_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_capture),
        .i_pop   (w_rx_pop),
        .i_wdata (rx_data),
        .o_head  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    always_comb begin
        w_rdata_next = 8'h00;
        if (w_rd_data && !w_rx_empty) w_rdata_next = w_rx_head;
        else if (w_rd_lsr)            w_rdata_next = w_lsr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_rdata   <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            r_ack   <= bus_en;
            r_rdata <= bus_en ? w_rdata_next : 8'h00;
            // A drop in the same cycle as the LSR read keeps the flag set.
            if (w_rx_drop)     r_overrun <= 1'b1;
            else if (w_rd_lsr) r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state    <= c_TX_IDLE;
            r_tx_wait_cnt <= 2'd0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_tx_state)
                c_TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_start    <= 1'b1;
                        r_tx_data     <= w_tx_head;
                        r_tx_wait_cnt <= 2'd0;
                        r_tx_state    <= c_TX_WAIT_BUSY;
                    end
                end
                c_TX_WAIT_BUSY: begin
                    // Give up after four quiet cycles so a silent transmitter cannot stall us.
                    if (tx_busy)                             r_tx_state <= c_TX_WAIT_DONE;
                    else if (r_tx_wait_cnt == c_BUSY_TIMEOUT) r_tx_state <= c_TX_IDLE;
                    else                                     r_tx_wait_cnt <= r_tx_wait_cnt + 2'd1;
                end
                c_TX_WAIT_DONE: begin
                    if (!tx_busy) r_tx_state <= c_TX_IDLE;
                end
                default: r_tx_state <= c_TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= c_RX_IDLE;
        end else begin
            case (r_rx_state)
                c_RX_IDLE:  if (rx_ready)  r_rx_state <= c_RX_CLEAR;
                c_RX_CLEAR:                r_rx_state <= c_RX_WAIT;
                c_RX_WAIT:  if (!rx_ready) r_rx_state <= c_RX_IDLE;
                default:                   r_rx_state <= c_RX_IDLE;
            endcase
        end
    end

    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign rx_clear  = (r_rx_state == c_RX_CLEAR);
endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_mmio_ctrl
//  Purpose  : Self-checking bench for uart_mmio_ctrl against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_mmio_ctrl;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;
    localparam int BUSY_LEN = 12;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       bus_en    = 1'b0;
    logic       bus_we    = 1'b0;
    logic [2:0] bus_addr  = 3'd0;
    logic [7:0] bus_wdata = 8'h00;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_clear;

    always #5 clk = ~clk;

    uart_mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_clear  (rx_clear)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model plus passive monitors.
    logic       tx_hold    = 1'b0;
    logic       mon_en     = 1'b1;
    int         tx_cnt     = 0;
    logic       prev_start = 1'b0;
    logic [7:0] last_tx    = 8'h00;
    logic [7:0] tx_seen[$];
    int         rx_clr_cnt = 0;
    int         ack_cnt    = 0;
    int         stab_err   = 0;
    int         pulse_err  = 0;

    assign tx_busy = tx_hold | (tx_cnt != 0);

    always @(posedge clk) begin
        if (mon_en && tx_cnt != 0 && tx_data !== last_tx) stab_err <= stab_err + 1;
        if (tx_start && prev_start) pulse_err <= pulse_err + 1;
        prev_start <= tx_start;
        if (tx_start) begin
            tx_seen.push_back(tx_data);
            last_tx <= tx_data;
            tx_cnt  <= BUSY_LEN;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        if (rx_clear) rx_clr_cnt <= rx_clr_cnt + 1;
        if (bus_ack)  ack_cnt    <= ack_cnt + 1;
    end

    // Reference model state.
    logic [7:0] exp_tx[$];
    logic [7:0] m_rx[$];
    logic       m_ovr   = 1'b0;
    int         m_txn   = 0;
    int         tx_chk  = 0;
    int         acc_cnt = 0;
    logic [7:0] rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_acc(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                           output logic [7:0] rdv);
        @(negedge clk);
        bus_en = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00;
        acc_cnt++;
        check("bus_ack", {31'd0, bus_ack}, 32'd1);
        rdv = bus_rdata;
    endtask

    task automatic m_write(input logic [7:0] d);
        bus_acc(1'b1, 3'd0, d, rd);
        if (m_txn < TX_DEPTH) begin
            m_txn++;
            exp_tx.push_back(d);
        end
    endtask

    task automatic m_read();
        logic [7:0] e;
        bus_acc(1'b0, 3'd0, 8'h00, rd);
        if (m_rx.size() != 0) e = m_rx.pop_front();
        else                  e = 8'h00;
        check("rd_data", rd, e);
    endtask

    task automatic m_lsr(input string tag);
        logic [7:0] e;
        e = {1'b0, (m_txn == 0), (m_txn < TX_DEPTH), 3'b000, m_ovr, (m_rx.size() != 0)};
        bus_acc(1'b0, 3'd5, 8'h00, rd);
        check(tag, rd, e);
        m_ovr = 1'b0;
    endtask

    task automatic m_rsvd();
        logic [2:0] a;
        logic       we;
        a  = 3'($urandom_range(1, 7));
        we = (a == 3'd5) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_acc(we, a, 8'($urandom), rd);
        if (!we) check("rsvd_rd", rd, 0);
    endtask

    task automatic m_inject(input logic [7:0] d, input int extra);
        int c0;
        int t;
        c0 = rx_clr_cnt;
        t  = 0;
        @(negedge clk);
        rx_ready = 1'b1; rx_data = d;
        while (rx_clr_cnt == c0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (extra) @(negedge clk);
        rx_ready = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rx_clear_once", rx_clr_cnt - c0, 1);
        if (m_rx.size() < RX_DEPTH) m_rx.push_back(d);
        else                        m_ovr = 1'b1;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((tx_seen.size() < exp_tx.size() || tx_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain_timeout"}, {31'd0, t < 3000}, 1);
        repeat (4) @(negedge clk);
        check({tag, "_tx_count"}, tx_seen.size(), exp_tx.size());
        for (int i = tx_chk; i < exp_tx.size(); i++)
            if (i < tx_seen.size()) check({tag, "_tx_byte"}, tx_seen[i], exp_tx[i]);
        tx_chk = exp_tx.size();
        m_txn  = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;

        @(negedge clk);
        check("rst_ack",    bus_ack,   0);
        check("rst_rdata",  bus_rdata, 0);
        check("rst_start",  tx_start,  0);
        check("rst_txdata", tx_data,   0);
        check("rst_clear",  rx_clear,  0);
        rst = 1'b0;
        m_lsr("rst_lsr");

        // Single byte: start two cycles after the write strobe.
        @(negedge clk);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = 8'h41;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0;
        acc_cnt++;
        check("t1_ack", bus_ack, 1);
        check("t1_start_early", tx_start, 0);
        @(negedge clk);
        check("t1_start", tx_start, 1);
        check("t1_tx_data", tx_data, 8'h41);
        exp_tx.push_back(8'h41);
        bus_acc(1'b0, 3'd5, 8'h00, rd);
        check("t1_lsr_busy", rd, 8'h20);
        drain("t1");
        m_lsr("t1_lsr_idle");

        // Back-to-back burst overflowing the TX FIFO.
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            bus_en = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = 8'(k);
            @(negedge clk);
            acc_cnt++;
            check("t2_ack", bus_ack, 1);
        end
        bus_en = 1'b0; bus_we = 1'b0; bus_wdata = 8'h00;
        bus_acc(1'b0, 3'd5, 8'h00, rd);
        check("t2_lsr_full", rd, 8'h00);
        repeat (400) @(negedge clk);
        n = tx_seen.size() - tx_chk;
        check("t2_start_count_8_or_9", {31'd0, (n == 8 || n == 9)}, 1);
        for (int i = 0; i < n; i++) begin
            check("t2_order", tx_seen[tx_chk + i], 8'(i + 1));
            exp_tx.push_back(8'(i + 1));
        end
        tx_chk = exp_tx.size();
        m_lsr("t2_lsr_idle");

        // Single receive, then read-back and empty read.
        m_inject(8'h55, 0);
        m_lsr("t3_lsr_full");
        m_read();
        m_lsr("t3_lsr_empty");
        m_read();

        // RX overrun.
        for (int i = 0; i < 9; i++) m_inject(8'($urandom), 0);
        m_lsr("t4_lsr_ovr");
        for (int i = 0; i < 8; i++) m_read();
        m_lsr("t4_lsr_clr");

        // rx_ready held long after the clear.
        m_inject(8'hC3, 20);
        m_read();

        // Randomized rounds: transmitter stalled while ops are applied.
        for (int r = 0; r < 10; r++) begin
            tx_hold = 1'b1;
            for (int op = 0; op < 20; op++) begin
                case ($urandom_range(0, 5))
                    0, 1:    m_write(8'($urandom));
                    2, 3:    m_inject(8'($urandom), int'($urandom_range(0, 3)));
                    4:       m_read();
                    default: if ($urandom_range(0, 1) == 1) m_lsr("rnd_lsr"); else m_rsvd();
                endcase
            end
            tx_hold = 1'b0;
            drain("rnd");
            m_lsr("rnd_lsr_end");
        end

        // Reset while the transmitter is busy with bytes still queued.
        while (m_rx.size() != 0) m_read();
        m_lsr("t6_pre_lsr");
        bus_acc(1'b1, 3'd0, 8'hA5, rd);
        exp_tx.push_back(8'hA5);
        for (int i = 0; i < 3; i++) bus_acc(1'b1, 3'd0, 8'(8'h10 + i), rd);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_start",  tx_start,  0);
        check("t6_rst_txdata", tx_data,   0);
        check("t6_rst_clear",  rx_clear,  0);
        check("t6_rst_ack",    bus_ack,   0);
        check("t6_rst_rdata",  bus_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        m_txn = 0;
        m_lsr("t6_lsr");
        repeat (100) @(negedge clk);
        check("t6_no_start", tx_seen.size(), exp_tx.size());
        if (tx_seen.size() > tx_chk) check("t6_byte", tx_seen[tx_chk], 8'hA5);
        tx_chk = exp_tx.size();
        mon_en = 1'b1;

        check("ack_count", ack_cnt, acc_cnt);
        check("tx_data_stable", stab_err, 0);
        check("tx_start_pulse", pulse_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
